// File: rtl/gpio_axi_wctrl.sv
`default_nettype none
// ============================================================================
// Module   : gpio_axi_wctrl
// Brief    : AXI4-Lite write-channel controller committing one GPIO pin per
//            transaction. Define GPIO_WSTRB_EN to gate pin writes with Wstrb[0].
// Revision : 1.0 - initial release
// ============================================================================
module gpio_axi_wctrl #(
  parameter int                NPINS     = 8,
  parameter logic [NPINS-1:0]  RESET_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              AWvalid,
  output logic              AWready,
  input  logic [31:0]       AWaddr,
  input  logic              Wvalid,
  output logic              Wready,
  input  logic [31:0]       Wdata,
  input  logic [3:0]        Wstrb,
  output logic              Bvalid,
  input  logic              Bready,
  output logic [1:0]        Bresp,
  output logic [NPINS-1:0]  gpio_out,
  output logic              wr_pulse,
  output logic [3:0]        wr_index
);

  localparam logic [4:0] c_npins  = 5'(NPINS);
  localparam logic [1:0] c_okay   = 2'b00;
  localparam logic [1:0] c_slverr = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_DATA   = 3'd2,
    S_COMMIT = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_index;
  logic             r_data;
  logic             r_bvalid;
  logic [1:0]       r_bresp;
  logic             r_pulse;
  logic [3:0]       r_wr_index;
  logic [NPINS-1:0] r_gpio;
  logic [NPINS-1:0] w_mask;
  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_inrange;
  logic             w_strb;
  logic             w_wen;

  assign AWready = reset & ((r_state == S_IDLE) | (r_state == S_DATA));
  assign Wready  = reset & ((r_state == S_IDLE) | (r_state == S_ADDR));
  assign w_aw_hs = AWvalid & AWready;
  assign w_w_hs  = Wvalid & Wready;

  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_aw_hs && w_w_hs) w_next = S_COMMIT;
        else if (w_aw_hs)      w_next = S_ADDR;
        else if (w_w_hs)       w_next = S_DATA;
      end
      S_ADDR:   if (w_w_hs)  w_next = S_COMMIT;
      S_DATA:   if (w_aw_hs) w_next = S_COMMIT;
      S_COMMIT: w_next = S_RESP;
      S_RESP:   if (r_bvalid && Bready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_index <= 4'd0;
      r_data  <= 1'b0;
    end else begin
      if (w_aw_hs) r_index <= AWaddr[3:0];
      if (w_w_hs)  r_data  <= Wdata[0];
    end
  end

`ifdef GPIO_WSTRB_EN
  logic r_strb;
  always_ff @(posedge clock) begin
    if (!reset)      r_strb <= 1'b0;
    else if (w_w_hs) r_strb <= Wstrb[0];
  end
  assign w_strb = r_strb;
  logic w_unused_bits;
  assign w_unused_bits = ^{AWaddr[31:4], Wdata[31:1], Wstrb[3:1]};
`else
  assign w_strb = 1'b1;
  logic w_unused_bits;
  assign w_unused_bits = ^{AWaddr[31:4], Wdata[31:1], Wstrb};
`endif

  // Indices at or above NPINS answer SLVERR and never touch a pin.
  assign w_inrange = ({1'b0, r_index} < c_npins);
  assign w_wen     = (r_state == S_COMMIT) & w_inrange & w_strb;

  for (genvar i = 0; i < NPINS; i++) begin : g_pin
    assign w_mask[i] = w_wen & (r_index == 4'(i));
  end

  always_ff @(posedge clock) begin
    if (!reset) r_gpio <= RESET_VAL;
    else        r_gpio <= (r_gpio & ~w_mask) | (w_mask & {NPINS{r_data}});
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_bvalid   <= 1'b0;
      r_bresp    <= c_okay;
      r_pulse    <= 1'b0;
      r_wr_index <= 4'd0;
    end else begin
      r_pulse <= w_wen;
      if (r_state == S_COMMIT) begin
        r_bvalid   <= 1'b1;
        r_bresp    <= w_inrange ? c_okay : c_slverr;
        r_wr_index <= r_index;
      end else if ((r_state == S_RESP) && Bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  assign Bvalid   = r_bvalid;
  assign Bresp    = r_bresp;
  assign wr_pulse = r_pulse;
  assign wr_index = r_wr_index;
  assign gpio_out = r_gpio;

endmodule
`default_nettype wire

// File: tb/tb_gpio_axi_wctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_axi_wctrl
// Brief    : Directed vector bench for gpio_axi_wctrl (NPINS=8, RESET_VAL=0x81).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_axi_wctrl;

  localparam int         c_npins = 8;
  localparam logic [7:0] c_rst   = 8'h81;

  logic        clock;
  logic        reset;
  logic        AWvalid, AWready;
  logic [31:0] AWaddr;
  logic        Wvalid, Wready;
  logic [31:0] Wdata;
  logic [3:0]  Wstrb;
  logic        Bvalid, Bready;
  logic [1:0]  Bresp;
  logic [7:0]  gpio_out;
  logic        wr_pulse;
  logic [3:0]  wr_index;

  int n_chk  = 0;
  int n_fail = 0;

  gpio_axi_wctrl #(.NPINS(c_npins), .RESET_VAL(c_rst)) dut (
    .clock(clock), .reset(reset),
    .AWvalid(AWvalid), .AWready(AWready), .AWaddr(AWaddr),
    .Wvalid(Wvalid), .Wready(Wready), .Wdata(Wdata), .Wstrb(Wstrb),
    .Bvalid(Bvalid), .Bready(Bready), .Bresp(Bresp),
    .gpio_out(gpio_out), .wr_pulse(wr_pulse), .wr_index(wr_index)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [7:0]  exp_gpio;
    logic [1:0]  exp_resp;
    logic        exp_pulse;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  // Simultaneous AW+W with Bready high; checks commit and response timing.
  task automatic write_both(input vec_t v, input string nm);
    int t = 0;
    @(negedge clock);
    while (!(AWready && Wready) && t < 8) begin
      @(negedge clock);
      t++;
    end
    chk({nm, " ready"}, {30'd0, AWready, Wready}, 32'd3);
    AWvalid = 1'b1; AWaddr = v.addr;
    Wvalid  = 1'b1; Wdata  = v.data; Wstrb = v.strb;
    Bready  = 1'b1;
    step();
    AWvalid = 1'b0; Wvalid = 1'b0;
    chk({nm, " bvalid early"}, {31'd0, Bvalid}, 32'd0);
    step();
    chk({nm, " gpio"},   {24'd0, gpio_out}, {24'd0, v.exp_gpio});
    chk({nm, " pulse"},  {31'd0, wr_pulse}, {31'd0, v.exp_pulse});
    chk({nm, " bvalid"}, {31'd0, Bvalid},   32'd1);
    chk({nm, " bresp"},  {30'd0, Bresp},    {30'd0, v.exp_resp});
    chk({nm, " index"},  {28'd0, wr_index}, {28'd0, v.addr[3:0]});
    step();
    chk({nm, " bvalid done"}, {31'd0, Bvalid},   32'd0);
    chk({nm, " pulse done"},  {31'd0, wr_pulse}, 32'd0);
  endtask

  logic [7:0] exp_gpio;

  initial begin
    vecs[0] = '{32'h3,        32'h1,        4'hF, 8'h89, 2'b00, 1'b1};
    vecs[1] = '{32'h0,        32'h0,        4'hF, 8'h88, 2'b00, 1'b1};
    vecs[2] = '{32'hA,        32'h1,        4'hF, 8'h88, 2'b10, 1'b0};
    vecs[3] = '{32'h7,        32'h0,        4'hF, 8'h08, 2'b00, 1'b1};
    vecs[4] = '{32'hFFFFFFF6, 32'hFFFFFFF3, 4'hF, 8'h48, 2'b00, 1'b1};
    vecs[5] = '{32'h8,        32'h1,        4'hF, 8'h48, 2'b10, 1'b0};
    vecs[6] = '{32'hF,        32'h1,        4'hF, 8'h48, 2'b10, 1'b0};
`ifdef GPIO_WSTRB_EN
    vecs[7] = '{32'h2,        32'h1,        4'h0, 8'h48, 2'b00, 1'b0};
`else
    vecs[7] = '{32'h2,        32'h1,        4'h0, 8'h4C, 2'b00, 1'b1};
`endif

    reset = 1'b0; AWvalid = 1'b0; AWaddr = '0; Wvalid = 1'b0;
    Wdata = '0; Wstrb = '0; Bready = 1'b0;
    repeat (3) step();
    chk("rst gpio",    {24'd0, gpio_out}, {24'd0, c_rst});
    chk("rst bvalid",  {31'd0, Bvalid},   32'd0);
    chk("rst bresp",   {30'd0, Bresp},    32'd0);
    chk("rst pulse",   {31'd0, wr_pulse}, 32'd0);
    chk("rst index",   {28'd0, wr_index}, 32'd0);
    chk("rst readies", {30'd0, AWready, Wready}, 32'd0);
    @(negedge clock); reset = 1'b1;
    step();
    chk("post-rst readies", {30'd0, AWready, Wready}, 32'd3);

    for (int i = 0; i < 8; i++) write_both(vecs[i], $sformatf("vec%0d", i));
    exp_gpio = vecs[7].exp_gpio;

    // W first, AW four cycles later.
    @(negedge clock); Wvalid = 1'b1; Wdata = 32'h1; Wstrb = 4'hF; Bready = 1'b1;
    step(); Wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("wfirst readies", {30'd0, AWready, Wready}, 32'd2);
      step();
    end
    @(negedge clock); AWvalid = 1'b1; AWaddr = 32'h5;
    step(); AWvalid = 1'b0;
    chk("wfirst gpio before", {24'd0, gpio_out}, {24'd0, exp_gpio});
    step();
    exp_gpio[5] = 1'b1;
    chk("wfirst gpio",  {24'd0, gpio_out}, {24'd0, exp_gpio});
    chk("wfirst pulse", {31'd0, wr_pulse}, 32'd1);
    chk("wfirst index", {28'd0, wr_index}, 32'd5);
    step();

    // Stalled response while a new address waits.
    @(negedge clock); Bready = 1'b0;
    AWvalid = 1'b1; AWaddr = 32'h1; Wvalid = 1'b1; Wdata = 32'h1;
    step(); Wvalid = 1'b0; AWaddr = 32'h4;
    step();
    exp_gpio[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall bvalid",  {31'd0, Bvalid},   32'd1);
      chk("stall bresp",   {30'd0, Bresp},    32'd0);
      chk("stall readies", {30'd0, AWready, Wready}, 32'd0);
      chk("stall pulse",   {31'd0, wr_pulse}, (i == 0) ? 32'd1 : 32'd0);
      chk("stall gpio",    {24'd0, gpio_out}, {24'd0, exp_gpio});
      step();
    end
    @(negedge clock); Bready = 1'b1;
    step();
    chk("stall released bvalid", {31'd0, Bvalid}, 32'd0);
    chk("stall aw idle ready",   {30'd0, AWready, Wready}, 32'd3);
    step(); AWvalid = 1'b0;
    chk("stall aw accepted", {30'd0, AWready, Wready}, 32'd1);
    @(negedge clock); Wvalid = 1'b1; Wdata = 32'h0;
    step(); Wvalid = 1'b0;
    step();
    chk("stall commit index", {28'd0, wr_index}, 32'd4);
    chk("stall commit gpio",  {24'd0, gpio_out}, {24'd0, exp_gpio});
    step();

    // Reset during a half-finished transaction.
    @(negedge clock); AWvalid = 1'b1; AWaddr = 32'h6;
    step(); AWvalid = 1'b0;
    @(negedge clock); reset = 1'b0;
    step(); step();
    chk("midrst gpio",    {24'd0, gpio_out}, {24'd0, c_rst});
    chk("midrst readies", {30'd0, AWready, Wready}, 32'd0);
    chk("midrst bvalid",  {31'd0, Bvalid},   32'd0);
    @(negedge clock); reset = 1'b1;
    step();
    chk("midrst idle", {30'd0, AWready, Wready}, 32'd3);
    chk("midrst no resp", {31'd0, Bvalid}, 32'd0);
    write_both('{32'h1, 32'h1, 4'hF, 8'h83, 2'b00, 1'b1}, "after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpio_axi_wctrl.md
# gpio_axi_wctrl

AXI4-Lite write-channel controller for the GPIO peripheral. It accepts the write address and write data in either order, latches them, and commits one pin register per transaction. It then returns a write response on the B channel. It sits between the AXI interconnect slave port and the GPIO pin output registers, and it owns the sequencing of the AW/W/B handshakes.

## Interface

Parameters:
- NPINS, 8: number of GPIO output pins, legal range 1..16.
- RESET_VAL, 0: reset value of the gpio_out vector, NPINS bits.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous reset, active-low
- AWvalid  in  1  write address valid
- AWready  out  1  write address ready
- AWaddr  in  32  write address; bits [3:0] form the pin index, bits [31:4] are ignored
- Wvalid  in  1  write data valid
- Wready  out  1  write data ready
- Wdata  in  32  write data; only bit 0 is used as the pin value
- Wstrb  in  4  byte strobes; only Wstrb[0] is used, see Configuration
- Bvalid  out  1  write response valid
- Bready  in  1  write response ready
- Bresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- gpio_out  out  NPINS  pin output registers
- wr_pulse  out  1  one-cycle strobe after a successful pin update
- wr_index  out  4  index of the last committed write, registered

## Operation

- States: IDLE, ADDR (address held, waiting for data), DATA (data held, waiting for address), COMMIT, RESP.
- Ready decode:
  - AWready = reset & (state==IDLE | state==DATA).
  - Wready = reset & (state==IDLE | state==ADDR).
  - Both readies are 0 while reset is low.
- IDLE transitions:
  - AW and W handshakes in the same cycle → COMMIT.
  - AW handshake only → ADDR.
  - W handshake only → DATA.
- ADDR: W handshake → COMMIT. DATA: AW handshake → COMMIT.
- Latching:
  - The address index register loads AWaddr[3:0] on each AW handshake.
  - The data bit and strobe bit load Wdata[0] and Wstrb[0] on each W handshake.
- COMMIT, for index < NPINS (and strobe set, if strobing is enabled):
  - gpio_out[index] is set to the latched data bit.
  - wr_pulse=1 for one cycle.
  - Bresp=OKAY.
- COMMIT, for index ≥ NPINS:
  - No register changes and wr_pulse stays 0.
  - Bresp=SLVERR.
- COMMIT, for an in-range index with the strobe clear (strobing enabled):
  - No write and wr_pulse stays 0.
  - Bresp=OKAY.
- Every COMMIT updates wr_index and asserts Bvalid, then moves to RESP.
- RESP: Bvalid and Bresp are held stable until Bready. On Bvalid & Bready, Bvalid clears → IDLE.
- Only one transaction is outstanding at a time. No new AW or W is accepted until the response completes.
- Reset values: state=IDLE, gpio_out=RESET_VAL, Bvalid=0, Bresp=00, wr_pulse=0, wr_index=0, latched index/data/strobe=0.
- Reset mid-transaction: the transaction is dropped and no response is issued. gpio_out returns to RESET_VAL.

## Timing

- Handshakes complete at rising edge k, when valid & ready are sampled high.
- Address and data in the same edge k:
  - COMMIT during cycle k..k+1.
  - At edge k+1: gpio_out updates, and wr_pulse and Bvalid rise.
- Address and data in different edges: count k from the later of the two handshakes.
- Bready already high when Bvalid rises:
  - The response completes at edge k+2.
  - The next AW/W can be accepted at edge k+3.
  - Minimum transaction period is 3 cycles.
- wr_pulse is exactly one cycle wide, even when Bready is held low.
- Bvalid does not depend combinationally on Bready. AWready and Wready depend only on state and reset.

## Configuration

- GPIO_WSTRB_EN defined:
  - Wstrb[0] gates the pin write.
  - With strobe 0, the transaction completes with OKAY, no pin update, and no wr_pulse.
- GPIO_WSTRB_EN undefined:
  - Wstrb is ignored and every in-range write updates the pin.
  - The strobe latch is not implemented.

## Test plan

- Reset → all outputs match their reset values:
  - gpio_out=RESET_VAL, Bvalid=0, AWready=0 and Wready=0 while reset is low.
  - AWready=1 and Wready=1 on the first cycle after release.
- Simultaneous AW (addr 0x3) and W (data 1), Bready held 1:
  - gpio_out[3]=1 and wr_pulse=1 one cycle after the handshake.
  - Bresp=00; Bvalid high for 1 cycle.
- W (data 1) first, then AW (addr 0x5) 4 cycles later:
  - Wready=0 and AWready=1 while waiting.
  - gpio_out[5]=1 one cycle after the AW handshake.
- AW addr 0xA with NPINS=8:
  - Bresp=10, gpio_out unchanged, wr_pulse=0, wr_index=0xA.
- Bready held low for 5 cycles after Bvalid:
  - Bvalid/Bresp stay stable; AWready=0 and Wready=0 throughout.
  - Reasserting AWvalid is not accepted until the cycle after the B handshake.
- With GPIO_WSTRB_EN, write to addr 0x2 with Wstrb=4'b0000, Wdata=1:
  - Bresp=00, gpio_out[2] unchanged, wr_pulse=0.
- Without GPIO_WSTRB_EN, the same write:
  - gpio_out[2]=1.
